// File: rtl/cross_bar_pkg.sv
// rtl/cross_bar_pkg.sv - shared cross-bar types and slave memory constants
// Purpose: address/data types, slave command encoding, slave FSM states and
//          default timing parameters used by the cross-bar slave memory.
// Ports:   none (package).
package cross_bar_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } slave_cmd_t;

  localparam int ACK_DELAY_DEF  = 1;
  localparam int RD_LATENCY_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK_WAIT,
    ST_ACK,
    ST_RD_WAIT,
    ST_RESP
  } slave_state_t;

endpackage

// File: rtl/cross_bar_slave_mem_if.sv
// rtl/cross_bar_slave_mem_if.sv - request/ack/resp bus of the cross-bar slave memory
// Purpose: bundles the slave port signals between a cross-bar master and the
//          slave memory.
// Ports:   req/addr/cmd/wdata driven by the master; ack/resp/rdata/busy driven
//          by the slave. Clock and reset are kept outside the interface.
interface cross_bar_slave_mem_if;
  import cross_bar_pkg::*;

  logic  req;
  addr_t addr;
  logic  cmd;
  data_t wdata;
  logic  ack;
  logic  resp;
  data_t rdata;
  logic  busy;

  modport master (
    output req, addr, cmd, wdata,
    input  ack, resp, rdata, busy
  );

  modport slave (
    input  req, addr, cmd, wdata,
    output ack, resp, rdata, busy
  );

endinterface

// File: rtl/cross_bar_slave_ram.sv
// rtl/cross_bar_slave_ram.sv - word storage for the cross-bar slave memory
// Purpose: DEPTH x DATA_W register array, synchronous write, combinational
//          read, cleared to zero by reset.
// Ports:   clk, rst (async active-high); we/waddr/wdata write port;
//          raddr/rdata combinational read port.
module cross_bar_slave_ram
  import cross_bar_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  data_t            wdata,
  input  logic [IDX_W-1:0] raddr,
  output data_t            rdata
);

  data_t mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cross_bar_slave_mem.sv
// rtl/cross_bar_slave_mem.sv - cross-bar slave memory with delayed ack and read latency
// Purpose: accepts one request at a time, acks it ACK_DELAY cycles after
//          detection, writes or reads a word at the ack handshake, and returns
//          read data RD_LATENCY cycles after the handshake.
// Ports:   clk, rst (async active-high); bus (slave modport): req/addr/cmd/wdata
//          in, ack/resp/rdata/busy out (all outputs registered).
module cross_bar_slave_mem
  import cross_bar_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ACK_DELAY  = ACK_DELAY_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  cross_bar_slave_mem_if.slave  bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] ACK_LOAD = 4'(ACK_DELAY - 1);
  localparam logic [3:0] RD_LOAD  = 4'(RD_LATENCY - 1);

  slave_state_t     state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             resp_q, resp_d;
  logic             busy_q, busy_d;
  data_t            cap_q, cap_d;
  data_t            rdata_q, rdata_d;

  logic [IDX_W-1:0] idx;
  slave_cmd_t       cmd;
  logic             ram_we;
  data_t            ram_rdata;
  logic             unused_addr_bits;

  // Word index only; byte offset and upper bits alias onto the same words.
  assign idx              = bus.addr[IDX_W+1:2];
  assign unused_addr_bits = ^{bus.addr[ADDR_W-1:IDX_W+2], bus.addr[1:0]};
  assign cmd              = slave_cmd_t'(bus.cmd);

  // The edge that ends the ACK cycle is the handshake.
  assign ram_we = (state_q == ST_ACK) && (cmd == CMD_WRITE);

  cross_bar_slave_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (idx),
    .wdata (bus.wdata),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (ACK_DELAY == 1) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_ACK_WAIT;
            cnt_d   = ACK_LOAD;
          end
        end
      end
      ST_ACK_WAIT: begin
        // Dropping req before the ack abandons the request silently.
        if (!bus.req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (cmd == CMD_WRITE) begin
          state_d = ST_IDLE;
        end else if (RD_LATENCY == 1) begin
          state_d = ST_RESP;
          rdata_d = ram_rdata;
        end else begin
          state_d = ST_RD_WAIT;
          cnt_d   = RD_LOAD;
          cap_d   = ram_rdata;
        end
      end
      ST_RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          // rdata only changes when resp is raised, so it holds between reads.
          rdata_d = cap_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ack_d  = (state_d == ST_ACK);
    resp_d = (state_d == ST_RESP);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.resp  = resp_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule
